// File: rtl/booth_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : booth_multiplier
// Purpose  : Sequential radix-4 Booth multiplier, signed/unsigned per op,
//            with zero-operand fast path and held result plus acknowledge.
// Revision : 1.0
// ============================================================================
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 productDone,
    input  logic                 productAck
);

    localparam int EXT    = WIDTH + 2;
    localparam int ACC_W  = 2 * EXT;
    localparam int DIGITS = WIDTH / 2 + 1;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [EXT-1:0]       r_mcand;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_qm1;
    logic [CNT_W-1:0]     r_count;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_done;

    logic                 w_zero;
    logic                 w_last;
    logic [EXT-1:0]       w_mplier_ext;
    logic [EXT-1:0]       w_mcand_ext;
    logic [EXT-1:0]       w_a;
    logic [EXT-1:0]       w_q;
    logic [2:0]           w_digit;
    logic [EXT+1:0]       w_m4;
    logic [EXT+1:0]       w_addend;
    logic [EXT+1:0]       w_sum;
    logic [ACC_W-1:0]     w_acc_next;

    assign w_zero       = (multiplier == '0) || (multiplicand == '0);
    assign w_last       = (r_count == CNT_W'(DIGITS - 1));
    assign w_mplier_ext = signed_op ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                    : {2'b00, multiplier};
    assign w_mcand_ext  = signed_op ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                    : {2'b00, multiplicand};

    // Accumulator holds {partial high part A, remaining multiplier bits Q};
    // the sum is formed two bits wider so the +/-2M digit can never overflow.
    assign w_a     = r_acc[ACC_W-1 -: EXT];
    assign w_q     = r_acc[EXT-1:0];
    assign w_digit = {w_q[1:0], r_qm1};
    assign w_m4    = {{2{r_mcand[EXT-1]}}, r_mcand};

    always_comb begin
        w_addend = '0;
        case (w_digit)
            3'b001, 3'b010: w_addend = w_m4;
            3'b011:         w_addend = w_m4 << 1;
            3'b100:         w_addend = -(w_m4 << 1);
            3'b101, 3'b110: w_addend = -w_m4;
            default:        w_addend = '0;
        endcase
    end

    assign w_sum      = {{2{w_a[EXT-1]}}, w_a} + w_addend;
    assign w_acc_next = {w_sum[EXT+1:2], w_sum[1:0], w_q[EXT-1:2]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_state_next = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_last)     w_state_next = S_DONE;
            S_DONE:  if (productAck) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_qm1     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= w_mcand_ext;
                        r_acc   <= {{EXT{1'b0}}, w_mplier_ext};
                        r_qm1   <= 1'b0;
                        r_count <= '0;
                        if (w_zero) begin
                            r_product <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_qm1   <= w_q[1];
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_product <= w_acc_next[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign product     = r_product;
    assign productDone = r_done;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// Directed testbench for booth_multiplier at WIDTH=8.
module tb_booth_multiplier;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            signed_op = 1'b0;
    logic            productAck = 1'b0;
    logic [W-1:0]    multiplier = '0;
    logic [W-1:0]    multiplicand = '0;
    logic            ready;
    logic            productDone;
    logic [2*W-1:0]  product;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_op    (signed_op),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .ready        (ready),
        .product      (product),
        .productDone  (productDone),
        .productAck   (productAck)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x;
        int y;
        x = s ? int'($signed(a)) : int'({24'd0, a});
        y = s ? int'($signed(b)) : int'({24'd0, b});
        return 16'(x * y);
    endfunction

    task automatic issue(input logic [7:0] mp, input logic [7:0] mc, input logic s,
                         input logic [15:0] exp, input int exp_lat, input string tag);
        int n;
        int lat;
        n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready_in"}, 32'(ready), 32'd1);
        multiplier   = mp;
        multiplicand = mc;
        signed_op    = s;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplier   = ~mp;
        multiplicand = ~mc;
        signed_op    = ~s;
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        lat = 0;
        while (!productDone && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_prod"}, 32'(product), 32'(exp));
    endtask

    task automatic ack(input int delay, input string tag);
        repeat (delay) tick();
        productAck = 1'b1;
        tick();
        productAck = 1'b0;
        chk({tag, "_ack_ready"}, 32'(ready), 32'd1);
        chk({tag, "_ack_done"}, 32'(productDone), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  mp;
        logic [7:0]  mc;
        logic        s;

        // Reset held from time zero: outputs must be cleared before any edge.
        #2;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(productDone), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 5, "u255x255");
        ack(0, "u255x255");
        issue(8'h80, 8'h80, 1'b1, 16'h4000, 5, "s_m128sq");
        ack(1, "s_m128sq");
        issue(8'hFF, 8'h01, 1'b1, 16'hFFFF, 5, "s_m1x1");
        ack(0, "s_m1x1");
        issue(8'h7F, 8'h80, 1'b1, 16'hC080, 5, "s_127xm128");
        ack(2, "s_127xm128");

        issue(8'h00, 8'h7B, 1'b0, 16'h0000, 0, "zero_u");
        ack(0, "zero_u");
        issue(8'h00, 8'h7B, 1'b1, 16'h0000, 0, "zero_s");
        ack(0, "zero_s");
        issue(8'h7B, 8'h00, 1'b0, 16'h0000, 0, "zero_b");
        ack(0, "zero_b");

        // Backpressure: result must hold and start pulses must be ignored.
        issue(8'h12, 8'h34, 1'b0, 16'h03A8, 5, "bp");
        for (int i = 0; i < 10; i++) begin
            start      = i[0];
            multiplier = 8'($urandom);
            tick();
            chk("bp_hold_done", 32'(productDone), 32'd1);
            chk("bp_hold_prod", 32'(product), 32'h03A8);
            chk("bp_hold_ready", 32'(ready), 32'd0);
        end
        start      = 1'b1;
        productAck = 1'b1;
        tick();
        productAck = 1'b0;
        start      = 1'b0;
        chk("bp_ack_ready", 32'(ready), 32'd1);
        chk("bp_ack_done", 32'(productDone), 32'd0);
        chk("bp_ack_prod", 32'(product), 32'h03A8);
        tick();
        chk("bp_no_capture", 32'(ready), 32'd1);

        // Reset in the third RUN cycle.
        multiplier   = 8'h55;
        multiplicand = 8'h66;
        signed_op    = 1'b0;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_done", 32'(productDone), 32'd0);
        chk("mid_rst_prod", 32'(product), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        tick();
        rst = 1'b1;
        repeat (6) tick();
        chk("post_rst_done", 32'(productDone), 32'd0);
        chk("post_rst_ready", 32'(ready), 32'd1);
        issue(8'd12, 8'd13, 1'b0, 16'h009C, 5, "u12x13");
        ack(0, "u12x13");

        for (int k = 0; k < 1000; k++) begin
            mp = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            mc = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            s  = 1'($urandom_range(0, 1));
            issue(mp, mc, s, ref_mul(mp, mc, s), (mp == 8'h00 || mc == 8'h00) ? 0 : 5, "rnd");
            ack(int'($urandom_range(0, 3)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
